// File: rtl/d_counter_pkg.sv
// Shared BCD digit type and increment helper for the d_counter decade counter.
package d_counter_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    typedef struct packed {
        logic       carry;
        bcd_digit_t next;
    } bcd_inc_t;

    // Codes A-F never occur in normal operation; any code >= 9 rolls to 0 so an
    // upset digit self-recovers, but only a true 9 propagates a carry.
    function automatic bcd_inc_t bcd_inc(input bcd_digit_t d);
        bcd_inc_t r;
        r.carry = (d == BCD_MAX);
        r.next  = (d >= BCD_MAX) ? '0 : d + 4'd1;
        return r;
    endfunction

endpackage

// File: rtl/d_counter_digit.sv
// One registered BCD digit of the d_counter chain; carry is combinational so
// the whole chain ripples within a single cycle.
module d_counter_digit
    import d_counter_pkg::*;
(
    input  logic       clock,
    input  logic       rst,
    input  logic       inc,
    output bcd_digit_t q,
    output logic       carry
);

    bcd_digit_t q_q;
    bcd_digit_t q_d;
    bcd_inc_t   step;

    always_comb begin
        step = bcd_inc(q_q);
        q_d  = inc ? step.next : q_q;
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign carry = inc & step.carry;

endmodule

// File: rtl/d_counter.sv
// NUM_DIGITS-digit packed-BCD up-counter with count enable.
// Optional macro D_COUNTER_WRAP_FLAG_EN adds a registered one-cycle wrap flag d_wrap.
module d_counter
    import d_counter_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic                    d_en,
    output logic [4*NUM_DIGITS-1:0] d_out
`ifdef D_COUNTER_WRAP_FLAG_EN
    ,
    output logic                    d_wrap
`endif
);

    // inc[i] enables digit i; inc[NUM_DIGITS] is the carry out of the top digit.
    logic [NUM_DIGITS:0] inc;

    assign inc[0] = d_en;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        d_counter_digit u_digit (
            .clock (clock),
            .rst   (rst),
            .inc   (inc[g]),
            .q     (d_out[4*g +: 4]),
            .carry (inc[g+1])
        );
    end

`ifdef D_COUNTER_WRAP_FLAG_EN
    logic wrap_q;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= inc[NUM_DIGITS];
        end
    end

    assign d_wrap = wrap_q;
`else
    logic unused_top_carry;
    assign unused_top_carry = inc[NUM_DIGITS];
`endif

endmodule

// File: tb/tb_d_counter.sv
// Directed self-checking bench for d_counter; honours D_COUNTER_WRAP_FLAG_EN.
module tb_d_counter;

    logic        clock;
    logic        rst;
    logic        d_en;
    logic [15:0] d_out;
`ifdef D_COUNTER_WRAP_FLAG_EN
    logic        d_wrap;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_cnt = 0;
    int wraps   = 0;
    int bad_nib = 0;

    d_counter #(.NUM_DIGITS(4)) dut (
        .clock (clock),
        .rst   (rst),
        .d_en  (d_en),
        .d_out (d_out)
`ifdef D_COUNTER_WRAP_FLAG_EN
        ,
        .d_wrap(d_wrap)
`endif
    );

    // Posedges at t = 20, 40, 60, ...; negedges at 30, 50, 70, ...
    initial begin
        clock = 1'b0;
        #20;
        forever begin
            clock = 1'b1;
            #10;
            clock = 1'b0;
            #10;
        end
    end

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered and left at a negedge; checks every cycle against the integer model.
    task automatic run(input string tag, input logic en, input int n);
        int   seg_bad;
        int   first_bad;
        logic exp_wrap;
        seg_bad   = 0;
        first_bad = -1;
        d_en = en;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            @(negedge clock);
            exp_wrap = en && (exp_cnt == 9999);
            if (en) exp_cnt = (exp_cnt + 1) % 10000;
            if (d_out !== to_bcd(exp_cnt)) begin
                seg_bad++;
                if (first_bad < 0) first_bad = i;
            end
            for (int k = 0; k < 4; k++) begin
                if (d_out[4*k +: 4] > 4'd9) bad_nib++;
            end
`ifdef D_COUNTER_WRAP_FLAG_EN
            if (d_wrap !== exp_wrap) begin
                seg_bad++;
                if (first_bad < 0) first_bad = i;
            end
            if (d_wrap === 1'b1) wraps++;
`else
            if (exp_wrap) wraps++;
`endif
        end
        n_cmp++;
        assert (seg_bad === 0) else begin
            n_fail++;
            $error("FAIL %s: observed %0d bad cycles (first at %0d, d_out=%h) expected 0",
                   tag, seg_bad, first_bad, d_out);
        end
    endtask

    initial begin
        // Reset with d_en unknown
        rst  = 1'b1;
        d_en = 1'bx;
        #5;
        chk("reset_async", 32'(d_out), 32'h0000);
        #35;
        rst  = 1'b0;
        d_en = 1'b0;
        #10;
        chk("reset_hold", 32'(d_out), 32'h0000);
`ifdef D_COUNTER_WRAP_FLAG_EN
        chk("wrap_reset", 32'(d_wrap), 32'h0);
`endif

        // Enable from t=50
        exp_cnt = 0;
        d_en = 1'b1;
        @(posedge clock);
        @(negedge clock);
        exp_cnt = 1;
        chk("first_count", 32'(d_out), 32'h0001);
        @(posedge clock);
        @(negedge clock);
        exp_cnt = 2;
        chk("second_count", 32'(d_out), 32'h0002);

        // Carry boundaries
        run("to_0009", 1'b1, 7);
        chk("at_0009", 32'(d_out), 32'h0009);
        run("carry_tens", 1'b1, 1);
        chk("at_0010", 32'(d_out), 32'h0010);
        run("to_0099", 1'b1, 89);
        chk("at_0099", 32'(d_out), 32'h0099);
        run("carry_hund", 1'b1, 1);
        chk("at_0100", 32'(d_out), 32'h0100);
        run("to_0999", 1'b1, 899);
        chk("at_0999", 32'(d_out), 32'h0999);
        run("carry_thou", 1'b1, 1);
        chk("at_1000", 32'(d_out), 32'h1000);

        // Mid-cycle async reset while enabled
        d_en = 1'b1;
        #5;
        rst = 1'b1;
        #1;
        chk("reset_midcycle", 32'(d_out), 32'h0000);
        @(posedge clock);
        @(negedge clock);
        chk("reset_over_edge", 32'(d_out), 32'h0000);
        rst = 1'b0;
        exp_cnt = 0;

        // Hold
        run("to_0123", 1'b1, 123);
        chk("at_0123", 32'(d_out), 32'h0123);
        run("hold", 1'b0, 5);
        chk("held_0123", 32'(d_out), 32'h0123);

        // Full wrap from 0000
        rst = 1'b1;
        #1;
        rst = 1'b0;
        exp_cnt = 0;
        wraps = 0;
        run("wrap_10000", 1'b1, 10000);
        chk("after_wrap", 32'(d_out), 32'h0000);
        chk("wrap_count_1", 32'(wraps), 32'd1);
`ifdef D_COUNTER_WRAP_FLAG_EN
        run("wrap_55561", 1'b1, 55561);
        chk("final_5561", 32'(d_out), 32'h5561);
        chk("wrap_count_6", 32'(wraps), 32'd6);
        run("wrap_idle", 1'b0, 2);
        chk("wrap_low", 32'(d_wrap), 32'h0);
`endif
        chk("no_af_nibble", 32'(bad_nib), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
